armleocpu_icache_responder: RTL

//  Responder side of the fetch-to-cache command interface (c_cmd/c_address -> c_done/c_response/c_load_data).

---
 rtl/armleocpu_icache_responder.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/armleocpu_icache_responder.sv
// Single-line instruction cache responder: serves fetch hits in one cycle and
// refills the line on a miss with one AXI4 INCR read burst.
module armleocpu_icache_responder #(
  parameter int unsigned LINE_WORDS_LOG2 = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  c_cmd,
  input  logic [31:0] c_address,
  output logic        c_done,
  output logic [3:0]  c_response,
  output logic [31:0] c_load_data,
  output logic        m_arvalid,
  input  logic        m_arready,
  output logic [31:0] m_araddr,
  output logic [7:0]  m_arlen,
  output logic [1:0]  m_arburst,
  input  logic        m_rvalid,
  output logic        m_rready,
  input  logic [31:0] m_rdata,
  input  logic [1:0]  m_rresp,
  input  logic        m_rlast
);

  localparam int unsigned LINE_WORDS = 1 << LINE_WORDS_LOG2;
  localparam int unsigned OFF_W      = LINE_WORDS_LOG2;
  localparam int unsigned TAG_LSB    = LINE_WORDS_LOG2 + 2;
  localparam int unsigned TAG_W      = 32 - TAG_LSB;

  localparam logic [3:0] CMD_NONE      = 4'd0;
  localparam logic [3:0] CMD_EXECUTE   = 4'd1;
  localparam logic [3:0] CMD_FLUSH_ALL = 4'd4;

  localparam logic [3:0] RESP_SUCCESS     = 4'd0;
  localparam logic [3:0] RESP_ACCESSFAULT = 4'd1;
  localparam logic [3:0] RESP_MISALIGNED  = 4'd3;
  localparam logic [3:0] RESP_UNKNOWNTYPE = 4'd4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t           state;
  logic             line_valid;
  logic [TAG_W-1:0] line_tag;
  logic [TAG_W-1:0] req_tag;
  logic [OFF_W-1:0] req_off;
  logic [OFF_W-1:0] beat_cnt;
  logic             beat_full;
  logic             err;
  logic [31:0]      req_word;
  logic [31:0]      words [LINE_WORDS];

  logic [TAG_W-1:0] c_tag;
  logic [OFF_W-1:0] c_off;
  logic             hit;
  logic             beat_hs;
  logic             beat_wr;
  logic             beat_err;

  // Address decode and beat qualification
  assign c_tag    = c_address[31:TAG_LSB];
  assign c_off    = c_address[TAG_LSB-1:2];
  assign hit      = line_valid && (line_tag == c_tag);
  assign beat_hs  = m_rvalid && m_rready;
  assign beat_wr  = beat_hs && !beat_full;
  assign beat_err = (m_rresp != 2'b00);

  assign m_arlen   = 8'(LINE_WORDS - 1);
  assign m_arburst = 2'b01;

  // Line storage: beats past the end of the line are dropped
  always_ff @(posedge clk) begin
    if (rst_n && (state == DATA) && beat_wr) begin
      words[beat_cnt] <= m_rdata;
    end
  end

  // Request FSM; RESP behaves as IDLE so a command is accepted while c_done is high
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      line_valid  <= 1'b0;
      line_tag    <= '0;
      req_tag     <= '0;
      req_off     <= '0;
      beat_cnt    <= '0;
      beat_full   <= 1'b0;
      err         <= 1'b0;
      req_word    <= '0;
      c_done      <= 1'b0;
      c_response  <= RESP_SUCCESS;
      c_load_data <= '0;
      m_arvalid   <= 1'b0;
      m_araddr    <= '0;
      m_rready    <= 1'b0;
    end else begin
      c_done <= 1'b0;
      case (state)
        IDLE, RESP: begin
          state <= IDLE;
          case (c_cmd)
            CMD_NONE: begin
            end
            CMD_FLUSH_ALL: begin
              line_valid <= 1'b0;
              c_done     <= 1'b1;
              c_response <= RESP_SUCCESS;
            end
            CMD_EXECUTE: begin
              if (c_address[1:0] != 2'b00) begin
                c_done     <= 1'b1;
                c_response <= RESP_MISALIGNED;
              end else if (hit) begin
                c_done      <= 1'b1;
                c_response  <= RESP_SUCCESS;
                c_load_data <= words[c_off];
              end else begin
                req_tag    <= c_tag;
                req_off    <= c_off;
                line_valid <= 1'b0;
                m_araddr   <= {c_tag, {TAG_LSB{1'b0}}};
                m_arvalid  <= 1'b1;
                state      <= ADDR;
              end
            end
            default: begin
              c_done     <= 1'b1;
              c_response <= RESP_UNKNOWNTYPE;
            end
          endcase
        end
        ADDR: begin
          if (m_arready) begin
            m_arvalid <= 1'b0;
            m_rready  <= 1'b1;
            beat_cnt  <= '0;
            beat_full <= 1'b0;
            err       <= 1'b0;
            state     <= DATA;
          end
        end
        DATA: begin
          if (beat_hs) begin
            if (!beat_full) begin
              beat_cnt <= beat_cnt + OFF_W'(1);
              if (beat_cnt == OFF_W'(LINE_WORDS - 1)) begin
                beat_full <= 1'b1;
              end
              if (beat_cnt == req_off) begin
                req_word <= m_rdata;
              end
            end
            if (beat_err) begin
              err <= 1'b1;
            end
            if (m_rlast) begin
              m_rready <= 1'b0;
              c_done   <= 1'b1;
              state    <= RESP;
              if (err || beat_err) begin
                c_response  <= RESP_ACCESSFAULT;
                c_load_data <= '0;
              end else begin
                line_valid  <= 1'b1;
                line_tag    <= req_tag;
                c_response  <= RESP_SUCCESS;
                c_load_data <= (beat_wr && (beat_cnt == req_off)) ? m_rdata : req_word;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
